cga_pixel_fetch: RTL and testbench
==================================

CGA_PIXEL_FETCH -- requirements
Module: cga_pixel_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 19'h00000, VRAM byte base added to every fetch address.
REQ-002 Parameter FIFO_DEPTH, default 4, number of {attr,char} words buffered; fixed at 4 for this revision.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_l  in  1  one clock; reset is asynchronous and active-low.
REQ-005 line_start  in  1  one-cycle pulse; begin fetching one text row.
REQ-006 start_addr  in  13  character (word) address of the first cell, sampled on line_start.
REQ-007 char_count  in  7  number of cells to fetch (0..127), sampled on line_start.
REQ-008 pixel_addr  out  19  VRAM byte address presented to the VRAM read port.
REQ-009 pixel_read  out  1  high while pixel_addr carries a fetch request.
REQ-010 pixel_data  in  8  VRAM read data, valid the cycle after its address is presented.
REQ-011 fifo_data  out  16  head word {attr[15:8], char[7:0]}, first-word fall-through.
REQ-012 fifo_valid  out  1  FIFO non-empty.
REQ-013 fifo_ready  in  1  consumer pop; pops on clk edge when fifo_valid && fifo_ready.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states: IDLE, RD_CHAR, RD_ATTR, CAP_ATTR, WAIT_SPACE.
REQ-016 IDLE: on line_start with char_count != 0, latch start_addr into cur_addr and char_count into remaining; go to RD_CHAR if the FIFO has a free slot, else WAIT_SPACE.
REQ-017 IDLE: line_start with char_count == 0 flushes the FIFO and stays in IDLE.
REQ-018 RD_CHAR: pixel_addr = BASE_ADDR + {cur_addr,1'b0}; pixel_read = 1; next state RD_ATTR.
REQ-019 RD_ATTR: pixel_addr = BASE_ADDR + {cur_addr,1'b1}; pixel_read = 1; capture pixel_data as the char byte; next state CAP_ATTR.
REQ-020 CAP_ATTR: pixel_read = 0; capture pixel_data as the attr byte; push {attr,char}; cur_addr += 1 (13-bit wrap, 0x1FFF -> 0x0000); remaining -= 1.
REQ-021 CAP_ATTR exit: to IDLE if remaining becomes 0; else to RD_CHAR if occupancy after this cycle's push/pop < 4; else to WAIT_SPACE.
REQ-022 WAIT_SPACE: pixel_read = 0; go to RD_CHAR in the cycle after occupancy < 4.
REQ-023 Throughput is exactly 3 cycles per cell when the FIFO never fills; busy falls 3*char_count cycles after line_start.
REQ-024 pixel_addr holds its last value while pixel_read = 0.
REQ-025 The FSM enters RD_CHAR only with a free slot reserved, so a push never occurs when the FIFO is full.
REQ-026 A pop with fifo_valid = 0 is ignored; a simultaneous push and pop leaves occupancy unchanged.
REQ-027 line_start in any non-IDLE state aborts the current cell, discards partial bytes, flushes the FIFO, and restarts per REQ-016/017 in the same edge.
REQ-028 A flush takes priority over a pop or push in the same cycle.
REQ-029 Pixel data bytes are not inspected; 0xFF (snow) bytes pass through unmodified.

Reset
REQ-030 While reset_l = 0: state IDLE, pixel_addr = 0, pixel_read = 0, fifo_data = 0, fifo_valid = 0, busy = 0, FIFO empty, cur_addr = 0, remaining = 0.
REQ-031 Reset asserted mid-fetch drops all state immediately, with no partial push.
REQ-032 The first line_start is accepted on the first clk edge after reset_l rises.

Verification
REQ-033 BASE 0, VRAM[0..3] = 41,07,42,1F, start 0, count 2, fifo_ready = 1 -> pixel_addr sequence 0,1,2,3; fifo words 0x0741 then 0x1F42; busy high for 6 cycles.
REQ-034 start 0x1FFF, count 2 -> pixel_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-035 fifo_ready = 0, count 6 -> 4 words pushed, then WAIT_SPACE with pixel_read = 0; after fifo_ready = 1, the remaining 2 cells are fetched in order.
REQ-036 line_start (start 0x100, count 1) asserted during RD_ATTR of a count-5 row -> FIFO empty the next cycle; single word from bytes 0x200/0x201 follows.
REQ-037 line_start with count 0 -> busy stays 0, pixel_read stays 0, and any existing FIFO contents are flushed.
REQ-038 reset_l pulsed low during CAP_ATTR -> all outputs at reset values with no spurious push; a normal fetch succeeds after release.

Source files
------------

// File: rtl/cga_pixel_fetch.sv
// cga_pixel_fetch: fetches {char,attr} byte pairs of a text row from VRAM into a small first-word fall-through FIFO.
module cga_pixel_fetch #(
  parameter logic [18:0] BASE_ADDR  = 19'h00000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        line_start,
  input  logic [12:0] start_addr,
  input  logic [6:0]  char_count,
  output logic [18:0] pixel_addr,
  output logic        pixel_read,
  input  logic [7:0]  pixel_data,
  output logic [15:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, RD_CHAR, RD_ATTR, CAP_ATTR, WAIT_SPACE} state_t;
  state_t state, state_nxt;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nxt;
  logic [12:0] cur_addr;
  logic [6:0] remaining;
  logic [7:0] char_byte;
  logic [18:0] last_addr;
  logic start, flush, push, pop;
  assign start = line_start && char_count != 7'd0;
  assign flush = line_start && (state != IDLE || char_count == 7'd0);
  assign push = state == CAP_ATTR && !line_start;
  assign pop = fifo_valid && fifo_ready && !flush;
  assign cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign fifo_valid = cnt != '0;
  assign fifo_data = fifo_valid ? mem[rd_ptr] : 16'h0000;
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else state <= state_nxt;
  // An abort always flushes, so a restart from a busy state always has room.
  always_comb begin
    state_nxt = state;
    if (line_start)
      state_nxt = !start ? IDLE : (state != IDLE || cnt < FULL) ? RD_CHAR : WAIT_SPACE;
    else
      case (state)
        RD_CHAR:    state_nxt = RD_ATTR;
        RD_ATTR:    state_nxt = CAP_ATTR;
        CAP_ATTR:   state_nxt = remaining == 7'd1 ? IDLE : cnt_nxt < FULL ? RD_CHAR : WAIT_SPACE;
        WAIT_SPACE: state_nxt = cnt < FULL ? RD_CHAR : WAIT_SPACE;
        default:    state_nxt = IDLE;
      endcase
  end
  always_comb begin
    pixel_read = state == RD_CHAR || state == RD_ATTR;
    pixel_addr = state == RD_CHAR ? BASE_ADDR + {5'b0, cur_addr, 1'b0} :
                 state == RD_ATTR ? BASE_ADDR + {5'b0, cur_addr, 1'b1} : last_addr;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      cur_addr <= '0;
      remaining <= '0;
      char_byte <= '0;
      last_addr <= '0;
    end else begin
      if (pixel_read) last_addr <= pixel_addr;
      if (start) begin
        cur_addr <= start_addr;
        remaining <= char_count;
      end else if (push) begin
        cur_addr <= cur_addr + 13'd1;
        remaining <= remaining - 7'd1;
      end
      if (state == RD_ATTR) char_byte <= pixel_data;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {pixel_data, char_byte};
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt_nxt;
      end
    end
endmodule

// File: tb/tb_cga_pixel_fetch.sv
// tb_cga_pixel_fetch: directed checks of row fetch, wrap, back-pressure, abort, empty row and reset.
module tb_cga_pixel_fetch;
  logic clk = 0, reset_l = 0, line_start = 0, fifo_ready = 0;
  logic [12:0] start_addr = '0;
  logic [6:0] char_count = '0;
  logic [18:0] pixel_addr;
  logic pixel_read, fifo_valid, busy;
  logic [7:0] pixel_data = '0;
  logic [15:0] fifo_data;
  logic [7:0] vram [16384];
  logic [18:0] aq [$];
  logic [15:0] wq [$];
  int checks = 0, errors = 0;

  cga_pixel_fetch dut (.clk(clk), .reset_l(reset_l), .line_start(line_start), .start_addr(start_addr),
    .char_count(char_count), .pixel_addr(pixel_addr), .pixel_read(pixel_read), .pixel_data(pixel_data),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) pixel_data <= vram[pixel_addr[13:0]];

  task tick;
    @(posedge clk); #1;
  endtask

  task collect(input int n);
    aq.delete(); wq.delete();
    for (int i = 0; i < n; i++) begin
      if (pixel_read) aq.push_back(pixel_addr);
      if (fifo_valid && fifo_ready) wq.push_back(fifo_data);
      tick();
      line_start = 0;
    end
  endtask

  task row(input logic [12:0] sa, input logic [6:0] cnt);
    start_addr = sa; char_count = cnt; line_start = 1;
  endtask

  task test_reset;
    reset_l = 0;
    tick(); tick();
    checks++; if ({pixel_addr, pixel_read, fifo_data, fifo_valid, busy} !== 38'd0) begin errors++;
      $display("FAIL reset_outputs got addr=%h rd=%b data=%h vld=%b busy=%b exp all zero", pixel_addr, pixel_read, fifo_data, fifo_valid, busy); end
    reset_l = 1;
  endtask

  task test_basic;
    logic [18:0] ea [6];
    logic er [6];
    int bc;
    ea = '{19'd0, 19'd1, 19'd1, 19'd2, 19'd3, 19'd3};
    er = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bc = 0;
    fifo_ready = 1;
    row(13'h0000, 7'd2);
    tick(); line_start = 0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (pixel_read !== er[i] || pixel_addr !== ea[i]) begin errors++;
        $display("FAIL basic_addr cycle %0d got rd=%b addr=%h exp rd=%b addr=%h", i, pixel_read, pixel_addr, er[i], ea[i]); end
      if (i == 3) begin
        checks++; if (!fifo_valid || fifo_data !== 16'h0741) begin errors++;
          $display("FAIL basic_word0 got vld=%b data=%h exp 1 0741", fifo_valid, fifo_data); end
      end
      if (busy) bc++;
      tick();
    end
    checks++; if (bc != 6 || busy !== 1'b0) begin errors++;
      $display("FAIL basic_busy got cycles=%0d busy_after=%b exp 6 0", bc, busy); end
    checks++; if (!fifo_valid || fifo_data !== 16'h1F42) begin errors++;
      $display("FAIL basic_word1 got vld=%b data=%h exp 1 1f42", fifo_valid, fifo_data); end
    tick();
    checks++; if (fifo_valid !== 1'b0) begin errors++;
      $display("FAIL basic_drain got vld=%b exp 0", fifo_valid); end
  endtask

  task test_wrap;
    logic [18:0] ea [4];
    ea = '{19'h3FFE, 19'h3FFF, 19'h00000, 19'h00001};
    fifo_ready = 1;
    row(13'h1FFF, 7'd2);
    collect(9);
    checks++; if (aq.size() != 4) begin errors++;
      $display("FAIL wrap_count got %0d exp 4", aq.size()); end
    for (int i = 0; i < 4 && i < aq.size(); i++) begin
      checks++; if (aq[i] !== ea[i]) begin errors++;
        $display("FAIL wrap_addr %0d got %h exp %h", i, aq[i], ea[i]); end
    end
    checks++; if (wq.size() != 2 || wq[0] !== 16'h4433 || wq[1] !== 16'h0741) begin errors++;
      $display("FAIL wrap_words got n=%0d w0=%h w1=%h exp 2 4433 0741", wq.size(), wq.size() > 0 ? wq[0] : 16'h0, wq.size() > 1 ? wq[1] : 16'h0); end
  endtask

  task test_back_pressure;
    fifo_ready = 0;
    row(13'h0010, 7'd6);
    collect(16);
    checks++; if (aq.size() != 8 || busy !== 1'b1 || pixel_read !== 1'b0 || pixel_addr !== 19'h27) begin errors++;
      $display("FAIL bp_wait got reads=%0d busy=%b rd=%b addr=%h exp 8 1 0 00027", aq.size(), busy, pixel_read, pixel_addr); end
    checks++; if (!fifo_valid || fifo_data !== 16'h7060) begin errors++;
      $display("FAIL bp_head got vld=%b data=%h exp 1 7060", fifo_valid, fifo_data); end
    fifo_ready = 1;
    collect(30);
    checks++; if (aq.size() != 4 || wq.size() != 6) begin errors++;
      $display("FAIL bp_resume got reads=%0d words=%0d exp 4 6", aq.size(), wq.size()); end
    for (int k = 0; k < 4 && k < aq.size(); k++) begin
      checks++; if (aq[k] !== 19'h28 + 19'(k)) begin errors++;
        $display("FAIL bp_addr %0d got %h exp %h", k, aq[k], 19'h28 + 19'(k)); end
    end
    for (int k = 0; k < 6 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== {8'h70 + 8'(k), 8'h60 + 8'(k)}) begin errors++;
        $display("FAIL bp_word %0d got %h exp %h", k, wq[k], {8'h70 + 8'(k), 8'h60 + 8'(k)}); end
    end
    checks++; if (busy !== 1'b0 || fifo_valid !== 1'b0) begin errors++;
      $display("FAIL bp_done got busy=%b vld=%b exp 0 0", busy, fifo_valid); end
  endtask

  task test_abort;
    fifo_ready = 0;
    row(13'h0010, 7'd5);
    tick(); line_start = 0;
    tick(); tick(); tick(); tick();
    checks++; if (pixel_read !== 1'b1 || pixel_addr !== 19'h23 || fifo_valid !== 1'b1) begin errors++;
      $display("FAIL abort_pre got rd=%b addr=%h vld=%b exp 1 00023 1", pixel_read, pixel_addr, fifo_valid); end
    row(13'h0100, 7'd1);
    tick(); line_start = 0;
    checks++; if (fifo_valid !== 1'b0 || pixel_read !== 1'b1 || pixel_addr !== 19'h200) begin errors++;
      $display("FAIL abort_flush got vld=%b rd=%b addr=%h exp 0 1 00200", fifo_valid, pixel_read, pixel_addr); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || fifo_valid !== 1'b1 || fifo_data !== 16'h1EFF) begin errors++;
      $display("FAIL abort_word got busy=%b vld=%b data=%h exp 0 1 1eff", busy, fifo_valid, fifo_data); end
    fifo_ready = 1;
    tick();
    checks++; if (fifo_valid !== 1'b0) begin errors++;
      $display("FAIL abort_single got vld=%b exp 0", fifo_valid); end
  endtask

  task test_zero_count;
    fifo_ready = 0;
    row(13'h0000, 7'd1);
    collect(5);
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 16'h0741) begin errors++;
      $display("FAIL zero_pre got vld=%b data=%h exp 1 0741", fifo_valid, fifo_data); end
    row(13'h0040, 7'd0);
    tick(); line_start = 0;
    checks++; if (busy !== 1'b0 || pixel_read !== 1'b0 || fifo_valid !== 1'b0) begin errors++;
      $display("FAIL zero_flush got busy=%b rd=%b vld=%b exp 0 0 0", busy, pixel_read, fifo_valid); end
    tick();
    checks++; if (busy !== 1'b0 || pixel_read !== 1'b0) begin errors++;
      $display("FAIL zero_idle got busy=%b rd=%b exp 0 0", busy, pixel_read); end
  endtask

  task test_reset_mid;
    fifo_ready = 0;
    row(13'h0000, 7'd3);
    tick(); line_start = 0;
    tick(); tick();
    reset_l = 0;
    #1;
    checks++; if ({pixel_addr, pixel_read, fifo_data, fifo_valid, busy} !== 38'd0) begin errors++;
      $display("FAIL rst_mid got addr=%h rd=%b data=%h vld=%b busy=%b exp all zero", pixel_addr, pixel_read, fifo_data, fifo_valid, busy); end
    tick();
    checks++; if (fifo_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_nopush got vld=%b busy=%b exp 0 0", fifo_valid, busy); end
    reset_l = 1;
    fifo_ready = 1;
    row(13'h0001, 7'd1);
    collect(6);
    checks++; if (aq.size() != 2 || wq.size() != 1 || aq[0] !== 19'h2 || wq[0] !== 16'h1F42) begin errors++;
      $display("FAIL rst_after got reads=%0d words=%0d a0=%h w0=%h exp 2 1 00002 1f42", aq.size(), wq.size(),
        aq.size() > 0 ? aq[0] : 19'h0, wq.size() > 0 ? wq[0] : 16'h0); end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) vram[a] = 8'h00;
    vram[0] = 8'h41; vram[1] = 8'h07; vram[2] = 8'h42; vram[3] = 8'h1F;
    vram[14'h3FFE] = 8'h33; vram[14'h3FFF] = 8'h44;
    for (int k = 0; k < 6; k++) begin
      vram[14'h20 + 14'(2*k)] = 8'h60 + 8'(k);
      vram[14'h21 + 14'(2*k)] = 8'h70 + 8'(k);
    end
    vram[14'h200] = 8'hFF; vram[14'h201] = 8'h1E;
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_abort();
    test_zero_count();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
